// File: rtl/cam_capture_if.sv
// Camera-to-frame-buffer bus bundle: camera byte stream in, pixel write strobe out.
// master: the capture block (samples camera pins, drives the write bus).
// slave:  the environment (drives camera pins, observes the write bus).
interface cam_capture_if #(
  parameter int ADDR_W = 19
);
  logic              cam_pclk;   // camera pixel clock, sampled as data
  logic              cam_vsync;  // high during vertical blank
  logic              cam_href;   // high while a line is valid
  logic [7:0]        cam_data;   // camera byte bus
  logic [ADDR_W-1:0] WriteAdd;   // frame buffer word address
  logic [11:0]       WriteData;  // {B[3:0], G[3:0], R[3:0]}
  logic              WriteEn;    // one-cycle write strobe

  modport master (
    input  cam_pclk, cam_vsync, cam_href, cam_data,
    output WriteAdd, WriteData, WriteEn
  );

  modport slave (
    output cam_pclk, cam_vsync, cam_href, cam_data,
    input  WriteAdd, WriteData, WriteEn
  );
endinterface

// File: rtl/cam_capture.sv
// Captures an 8-bit RGB444 camera stream (2 bytes/pixel), keeps every other pixel, writes the frame buffer.
// Latency: WriteEn one clk after the synchronized pclk tick of a kept pixel's second byte (3 clk after pclk rise).
// Backpressure: none; the frame buffer must accept every strobe, overrun writes are dropped and flagged.
// Ports: clk/rstn (sync, active-low); bus (camera pins in, WriteAdd/WriteData/WriteEn out);
//        cap_en (sampled at frame start); SyncVsync, frame_done pulses; ovf_err sticky overrun flag.
module cam_capture #(
  parameter int LINE_PIX    = 640,
  parameter int FRAME_WORDS = 153600,
  parameter int ADDR_W      = 19
) (
  input  logic            clk,
  input  logic            rstn,
  cam_capture_if.master   bus,
  input  logic            cap_en,
  output logic            SyncVsync,
  output logic            frame_done,
  output logic            ovf_err
);

  localparam int                COL_W    = $clog2(LINE_PIX + 1);
  localparam logic [COL_W-1:0]  COL_MAX  = COL_W'(LINE_PIX);
  localparam logic [ADDR_W-1:0] ADD_LAST = ADDR_W'(FRAME_WORDS - 1);

  typedef enum logic [1:0] {WAIT_VS, VBLANK, ACTIVE, SKIP} state_t;

  // Every camera input sees the same two-flop delay so data stays aligned with its pclk edge.
  logic       pclk_s1, pclk_s2, pclk_d3;
  logic       vs_s1, vs_s2, vs_d3;
  logic       href_s1, href_s2;
  logic [7:0] dat_s1, dat_s2;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      pclk_s1 <= 1'b0; pclk_s2 <= 1'b0; pclk_d3 <= 1'b0;
      vs_s1   <= 1'b0; vs_s2   <= 1'b0; vs_d3   <= 1'b0;
      href_s1 <= 1'b0; href_s2 <= 1'b0;
      dat_s1  <= '0;   dat_s2  <= '0;
    end else begin
      pclk_s1 <= bus.cam_pclk;  pclk_s2 <= pclk_s1;  pclk_d3 <= pclk_s2;
      vs_s1   <= bus.cam_vsync; vs_s2   <= vs_s1;    vs_d3   <= vs_s2;
      href_s1 <= bus.cam_href;  href_s2 <= href_s1;
      dat_s1  <= bus.cam_data;  dat_s2  <= dat_s1;
    end
  end

  logic tick, vs_fall, vs_rise;
  assign tick    = pclk_s2 & ~pclk_d3;
  assign vs_fall = vs_d3 & ~vs_s2;
  assign vs_rise = vs_s2 & ~vs_d3;

  state_t             state_q, state_d;
  logic               phase_q;
  logic [COL_W-1:0]   col_q;
  logic [3:0]         r_q;
  logic               frame_start, frame_end, pix_tick, write_due;
  logic               full_q;   // the write to ADD_LAST has been issued this frame
  logic               wr_en_q, sync_q, done_q, ovf_q;
  logic [ADDR_W-1:0]  wr_add_q;
  logic [11:0]        wr_dat_q;

  // FSM: state register
  always_ff @(posedge clk) begin
    if (!rstn) state_q <= WAIT_VS;
    else       state_q <= state_d;
  end

  // FSM: next state. WAIT_VS waits for blanking so a reset mid-frame never captures a partial frame.
  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT_VS: if (vs_s2)   state_d = VBLANK;
      VBLANK:  if (vs_fall) state_d = cap_en ? ACTIVE : SKIP;
      ACTIVE:  if (vs_rise) state_d = VBLANK;
      SKIP:    if (vs_rise) state_d = VBLANK;
      default:              state_d = WAIT_VS;
    endcase
  end

  // FSM: decoded controls
  always_comb begin
    frame_start = 1'b0;
    frame_end   = 1'b0;
    pix_tick    = 1'b0;
    case (state_q)
      VBLANK: frame_start = vs_fall;
      ACTIVE: begin
        frame_end = vs_rise;
        pix_tick  = tick & href_s2;
      end
      default: ;
    endcase
    // Only even columns are kept: the VGA side doubles pixels horizontally.
    write_due = pix_tick & phase_q & ~col_q[0] & (col_q < COL_MAX);
  end

  // Pixel assembly. Dropping href (or leaving ACTIVE) discards any odd trailing byte.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      phase_q <= 1'b0;
      col_q   <= '0;
      r_q     <= '0;
    end else if (state_q != ACTIVE || !href_s2) begin
      phase_q <= 1'b0;
      col_q   <= '0;
    end else if (tick) begin
      if (!phase_q) begin
        r_q     <= dat_s2[3:0];
        phase_q <= 1'b1;
      end else begin
        phase_q <= 1'b0;
        if (col_q != COL_MAX) col_q <= col_q + 1'b1;  // saturate on over-long lines
      end
    end
  end

  // Write port, frame pulses and overrun tracking.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_en_q  <= 1'b0;
      wr_add_q <= '0;
      wr_dat_q <= '0;
      full_q   <= 1'b0;
      ovf_q    <= 1'b0;
      sync_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      sync_q  <= frame_start;
      done_q  <= frame_end;
      if (frame_start) begin
        // Frame start wins over anything pending in the same cycle.
        wr_add_q <= '0;
        full_q   <= 1'b0;
        if (cap_en) ovf_q <= 1'b0;
      end else begin
        // Address advances after its strobe but never wraps past the last word.
        if (wr_en_q) begin
          if (wr_add_q == ADD_LAST) full_q   <= 1'b1;
          else                      wr_add_q <= wr_add_q + 1'b1;
        end
        if (write_due) begin
          if (full_q || (wr_en_q && wr_add_q == ADD_LAST)) begin
            ovf_q <= 1'b1;
          end else begin
            wr_en_q  <= 1'b1;
            wr_dat_q <= {dat_s2[3:0], dat_s2[7:4], r_q};
          end
        end
      end
    end
  end

  assign bus.WriteEn   = wr_en_q;
  assign bus.WriteAdd  = wr_add_q;
  assign bus.WriteData = wr_dat_q;
  assign SyncVsync     = sync_q;
  assign frame_done    = done_q;
  assign ovf_err       = ovf_q;

endmodule

// File: tb/tb_cam_capture.sv
// Bench for cam_capture with a reduced frame (8 camera pixels/line, 12 words/frame) so full,
// overrun and multi-frame sequences stay short. Camera pins are driven on clk negedges, pclk = clk/4.
module tb_cam_capture;

  localparam int LP = 8;   // camera pixels per line
  localparam int FW = 12;  // words per frame (3 full lines)
  localparam int AW = 19;

  logic clk, rstn, cap_en;
  logic SyncVsync, frame_done, ovf_err;

  cam_capture_if #(.ADDR_W(AW)) bus ();

  cam_capture #(.LINE_PIX(LP), .FRAME_WORDS(FW), .ADDR_W(AW)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .bus        (bus.master),
    .cap_en     (cap_en),
    .SyncVsync  (SyncVsync),
    .frame_done (frame_done),
    .ovf_err    (ovf_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---- monitor: records writes and pulse counts at negedges
  typedef struct packed {
    logic [AW-1:0] a;
    logic [11:0]   d;
  } wr_t;

  wr_t wr_q[$];
  int  n_sync = 0, n_done = 0, sync_run = 0, sync_wmax = 0;

  always @(negedge clk) begin
    if (bus.WriteEn) wr_q.push_back(wr_t'{a: bus.WriteAdd, d: bus.WriteData});
    if (SyncVsync) begin
      n_sync++;
      sync_run++;
      if (sync_run > sync_wmax) sync_wmax = sync_run;
    end else begin
      sync_run = 0;
    end
    if (frame_done) n_done++;
  end

  // ---- checking
  int n_checks = 0, n_err = 0;

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic check_wr(input string name, input int idx, input int exp_a, input int exp_d);
    if (idx >= wr_q.size()) begin
      check({name, "_missing"}, -1, exp_a);
    end else begin
      check({name, "_addr"}, int'(wr_q[idx].a), exp_a);
      check({name, "_data"}, int'(wr_q[idx].d), exp_d);
    end
  endtask

  // ---- camera drivers (all called at a negedge)
  task automatic send_byte(input logic [7:0] b);
    bus.cam_pclk = 1'b0;
    bus.cam_data = b;
    repeat (2) @(negedge clk);
    bus.cam_pclk = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic end_line();
    bus.cam_href = 1'b0;
    bus.cam_pclk = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic line_const(input int npix, input logic [7:0] b0, input logic [7:0] b1);
    bus.cam_href = 1'b1;
    for (int i = 0; i < npix; i++) begin
      send_byte(b0);
      send_byte(b1);
    end
    end_line();
  endtask

  task automatic frame_start();
    bus.cam_vsync = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic frame_stop();
    bus.cam_vsync = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  // ---- pixel table: {byte0, byte1} -> expected word {B,G,R} at address i
  typedef struct {
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [11:0] exp_d;
  } vec_t;

  vec_t tbl[FW];
  int   bw, bs, bd;
  logic [3:0] lat;
  int   first_add, first_dat;

  initial begin
    tbl[0]  = '{8'h0A, 8'h5C, 12'hC5A};
    tbl[1]  = '{8'h00, 8'h00, 12'h000};
    tbl[2]  = '{8'hFF, 8'hFF, 12'hFFF};
    tbl[3]  = '{8'h12, 8'h34, 12'h432};
    tbl[4]  = '{8'hF0, 8'h0F, 12'hF00};
    tbl[5]  = '{8'h0F, 8'hF0, 12'h0FF};
    tbl[6]  = '{8'h5A, 8'hA5, 12'h5AA};
    tbl[7]  = '{8'h81, 8'h7E, 12'hE71};
    tbl[8]  = '{8'hC3, 8'h96, 12'h693};
    tbl[9]  = '{8'h2D, 8'hB4, 12'h4BD};
    tbl[10] = '{8'h6E, 8'h19, 12'h91E};
    tbl[11] = '{8'hA7, 8'hC8, 12'h8C7};

    rstn = 1'b0; cap_en = 1'b1;
    bus.cam_pclk = 1'b0; bus.cam_vsync = 1'b0; bus.cam_href = 1'b0; bus.cam_data = 8'h00;
    repeat (4) @(negedge clk);
    check("rst_SyncVsync", SyncVsync, 0);
    check("rst_WriteEn", bus.WriteEn, 0);
    check("rst_WriteAdd", bus.WriteAdd, 0);
    check("rst_WriteData", bus.WriteData, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_ovf_err", ovf_err, 0);

    // Reset released mid-frame: lines arrive with vsync low, nothing may be written.
    rstn = 1'b1;
    bw = wr_q.size(); bs = n_sync;
    line_const(LP, 8'h0A, 8'h5C);
    line_const(LP, 8'h0A, 8'h5C);
    check("midframe_no_write", wr_q.size() - bw, 0);
    frame_stop();
    check("vs_high_no_sync", n_sync - bs, 0);
    frame_start();
    check("first_sync_count", n_sync - bs, 1);
    check("sync_width", sync_wmax, 1);

    // One line of (0x0A,0x5C) pairs; first write latency checked cycle by cycle.
    bw = wr_q.size(); bd = n_done;
    bus.cam_href = 1'b1;
    send_byte(8'h0A);
    bus.cam_pclk = 1'b0; bus.cam_data = 8'h5C;
    repeat (2) @(negedge clk);
    bus.cam_pclk = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      lat[k] = bus.WriteEn;
      if (k == 2) begin
        first_add = int'(bus.WriteAdd);
        first_dat = int'(bus.WriteData);
      end
    end
    check("first_wr_latency", lat, 4'b0100);
    check("first_wr_addr", first_add, 0);
    check("first_wr_data", first_dat, 12'hC5A);
    for (int i = 1; i < LP; i++) begin
      send_byte(8'h0A);
      send_byte(8'h5C);
    end
    end_line();
    frame_stop();
    check("line_write_count", wr_q.size() - bw, LP / 2);
    for (int i = 0; i < LP / 2; i++) check_wr($sformatf("line_w%0d", i), bw + i, i, 12'hC5A);
    check("line_frame_done", n_done - bd, 1);
    check("line_ovf", ovf_err, 0);

    // Full frame driven from the table; odd columns carry 0xFF filler that must not be written.
    bw = wr_q.size(); bd = n_done;
    frame_start();
    for (int l = 0; l < FW / (LP / 2); l++) begin
      bus.cam_href = 1'b1;
      for (int p = 0; p < LP / 2; p++) begin
        send_byte(tbl[l * (LP / 2) + p].b0);
        send_byte(tbl[l * (LP / 2) + p].b1);
        send_byte(8'hFF);
        send_byte(8'hFF);
      end
      end_line();
    end
    frame_stop();
    check("full_write_count", wr_q.size() - bw, FW);
    for (int i = 0; i < FW; i++) check_wr($sformatf("tbl%0d", i), bw + i, i, int'(tbl[i].exp_d));
    check("full_frame_done", n_done - bd, 1);
    check("full_ovf", ovf_err, 0);
    check("full_last_addr", bus.WriteAdd, FW - 1);

    // Overrun frame (4 lines); cap_en dropped during the last line must not cut the frame short.
    bw = wr_q.size(); bd = n_done;
    frame_start();
    for (int l = 0; l < 3; l++) line_const(LP, 8'h0A, 8'h5C);
    cap_en = 1'b0;
    line_const(LP, 8'h0A, 8'h5C);
    frame_stop();
    check("ovf_write_count", wr_q.size() - bw, FW);
    check_wr("ovf_last", bw + FW - 1, FW - 1, 12'hC5A);
    check("ovf_addr_no_wrap", bus.WriteAdd, FW - 1);
    check("ovf_flag", ovf_err, 1);
    check("ovf_frame_done", n_done - bd, 1);

    // Skipped frame: no writes or frame_done, SyncVsync still pulses, ovf_err held.
    bw = wr_q.size(); bd = n_done; bs = n_sync;
    frame_start();
    line_const(LP, 8'h0A, 8'h5C);
    line_const(LP, 8'h0A, 8'h5C);
    frame_stop();
    check("skip_writes", wr_q.size() - bw, 0);
    check("skip_done", n_done - bd, 0);
    check("skip_sync", n_sync - bs, 1);
    check("skip_ovf_held", ovf_err, 1);

    // Capture re-enabled: overrun cleared, addresses restart; odd trailing byte is discarded.
    cap_en = 1'b1;
    bw = wr_q.size(); bd = n_done;
    frame_start();
    check("ovf_cleared", ovf_err, 0);
    bus.cam_href = 1'b1;
    send_byte(8'h0A); send_byte(8'h5C); send_byte(8'h37);
    end_line();
    bus.cam_href = 1'b1;
    send_byte(8'h01); send_byte(8'h23);
    end_line();
    frame_stop();
    check("odd_write_count", wr_q.size() - bw, 2);
    check_wr("odd_w0", bw, 0, 12'hC5A);
    check_wr("odd_w1", bw + 1, 1, 12'h321);
    check("odd_frame_done", n_done - bd, 1);

    // Reset in the middle of a captured line: partial frame discarded until the next frame start.
    frame_start();
    bus.cam_href = 1'b1;
    send_byte(8'h0A); send_byte(8'h5C); send_byte(8'h0A);
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst_WriteAdd", bus.WriteAdd, 0);
    check("midrst_WriteEn", bus.WriteEn, 0);
    rstn = 1'b1;
    bw = wr_q.size();
    send_byte(8'h5C);
    line_const(LP, 8'h0A, 8'h5C);
    check("midrst_no_write", wr_q.size() - bw, 0);
    frame_stop();
    bs = n_sync;
    frame_start();
    check("midrst_sync", n_sync - bs, 1);
    line_const(LP, 8'h12, 8'h34);
    frame_stop();
    check("midrst_write_count", wr_q.size() - bw, LP / 2);
    check_wr("midrst_w0", bw, 0, 12'h432);
    check("sync_width_all", sync_wmax, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
